// File: rtl/cpu_bus_ctrl_pkg.sv
// cpu_bus_ctrl_pkg: MCS8 sequencer state, cycle and cycle-type codes
package cpu_bus_ctrl_pkg;
   localparam logic [2:0] ST_T1    = 3'b010;
   localparam logic [2:0] ST_T1I   = 3'b110;
   localparam logic [2:0] ST_T2    = 3'b100;
   localparam logic [2:0] ST_T3    = 3'b001;
   localparam logic [2:0] ST_WAIT  = 3'b000;
   localparam logic [1:0] CYC_C1   = 2'b00;
   localparam logic [1:0] CYC_INIT = 2'b11;
   localparam logic [1:0] CT_PCW   = 2'b11;
endpackage

// File: rtl/cpu_bus_ctrl_sync.sv
// cpu_bus_ctrl_sync: SYNC phase toggle and state-edge strobe
module cpu_bus_ctrl_sync (
   input  logic CLK1_I,
   input  logic nRST_I,
   output logic SYNC_O,
   output logic STB_O
);
   // SYNC flips every clock; the edge that sees it high is the sequencer's state edge
   always_ff @(posedge CLK1_I)
      if (!nRST_I) SYNC_O <= 1'b0;
      else SYNC_O <= ~SYNC_O;
   assign STB_O = SYNC_O;
endmodule

// File: rtl/cpu_bus_ctrl.sv
// cpu_bus_ctrl: 8008-style multiplexed bus controller paced by the MCS8 state sequencer
module cpu_bus_ctrl
   import cpu_bus_ctrl_pkg::*;
#(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 8
) (
   input  logic              CLK1_I,
   input  logic              nRST_I,
   input  logic [2:0]        STATE_I,
   input  logic [1:0]        CYCLE_I,
   input  logic [1:0]        CTYPE_I,
   input  logic [ADDR_W-1:0] ADDR_I,
   input  logic [DATA_W-1:0] WDATA_I,
   input  logic [DATA_W-1:0] D_I,
   output logic              SYNC_O,
   output logic [2:0]        S_O,
   output logic [DATA_W-1:0] D_O,
   output logic              D_OE_O,
   output logic [DATA_W-1:0] IR_O,
   output logic              IR_VLD_O,
   output logic [DATA_W-1:0] RDATA_O,
   output logic              RDATA_VLD_O,
   output logic              INTA_O,
   output logic              PC_HOLD_O
);
   logic stb;
   logic intack;
   cpu_bus_ctrl_sync u_sync (.CLK1_I, .nRST_I, .SYNC_O, .STB_O(stb));
   assign PC_HOLD_O = intack;
   // state pins mirror the sequencer one clock late, blanked during INIT
   always_ff @(posedge CLK1_I)
      if (!nRST_I) S_O <= 3'b000;
      else S_O <= (CYCLE_I == CYC_INIT) ? 3'b000 : STATE_I;
   // bus drive, capture and interrupt-ack tracking, advanced only on state edges
   always_ff @(posedge CLK1_I) begin
      if (!nRST_I) begin
         D_O         <= '0;
         D_OE_O      <= 1'b0;
         IR_O        <= '0;
         IR_VLD_O    <= 1'b0;
         RDATA_O     <= '0;
         RDATA_VLD_O <= 1'b0;
         INTA_O      <= 1'b0;
         intack      <= 1'b0;
      end else begin
         IR_VLD_O    <= 1'b0;
         RDATA_VLD_O <= 1'b0;
         INTA_O      <= 1'b0;
         if (stb) begin
            if (CYCLE_I == CYC_INIT) begin
               D_OE_O <= 1'b0;
               intack <= 1'b0;
            end else if (STATE_I == ST_T1 || STATE_I == ST_T1I) begin
               D_O    <= ADDR_I[7:0];
               D_OE_O <= 1'b1;
               if (STATE_I == ST_T1I) intack <= 1'b1;
            end else if (STATE_I == ST_T2) begin
               D_O    <= {CTYPE_I, ADDR_I[ADDR_W-1:8]};
               D_OE_O <= 1'b1;
            end else if ((STATE_I == ST_T3 || STATE_I == ST_WAIT) && CTYPE_I == CT_PCW) begin
               D_O    <= WDATA_I;
               D_OE_O <= 1'b1;
            end else begin
               D_OE_O <= 1'b0;
               if (STATE_I == ST_T3) begin
                  if (CYCLE_I == CYC_C1) begin
                     IR_O     <= D_I;
                     IR_VLD_O <= 1'b1;
                     INTA_O   <= intack;
                     intack   <= 1'b0;
                  end else begin
                     RDATA_O     <= D_I;
                     RDATA_VLD_O <= 1'b1;
                  end
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// tb_cpu_bus_ctrl: directed bus-cycle scenarios checked against a cycle-count based model
module tb_cpu_bus_ctrl;
   localparam logic [2:0] T1 = 3'b010, T1I = 3'b110, T2 = 3'b100, T3 = 3'b001;
   localparam logic [2:0] T4 = 3'b111, T5 = 3'b101, WT = 3'b000, STP = 3'b011;
   localparam logic [1:0] C1 = 2'b00, C2 = 2'b01, C3 = 2'b10, CI = 2'b11;
   localparam logic [1:0] PCI = 2'b00, PCR = 2'b10, PCW = 2'b11;

   logic        CLK1_I, nRST_I;
   logic [2:0]  STATE_I;
   logic [1:0]  CYCLE_I, CTYPE_I;
   logic [13:0] ADDR_I;
   logic [7:0]  WDATA_I, D_I;
   logic        SYNC_O, D_OE_O, IR_VLD_O, RDATA_VLD_O, INTA_O, PC_HOLD_O;
   logic [2:0]  S_O;
   logic [7:0]  D_O, IR_O, RDATA_O;

   cpu_bus_ctrl dut (
      .CLK1_I(CLK1_I), .nRST_I(nRST_I), .STATE_I(STATE_I), .CYCLE_I(CYCLE_I), .CTYPE_I(CTYPE_I),
      .ADDR_I(ADDR_I), .WDATA_I(WDATA_I), .D_I(D_I), .SYNC_O(SYNC_O), .S_O(S_O), .D_O(D_O),
      .D_OE_O(D_OE_O), .IR_O(IR_O), .IR_VLD_O(IR_VLD_O), .RDATA_O(RDATA_O),
      .RDATA_VLD_O(RDATA_VLD_O), .INTA_O(INTA_O), .PC_HOLD_O(PC_HOLD_O)
   );

   int errors = 0;
   int checks = 0;
   bit armed = 0;

   initial CLK1_I = 0;
   always #5 CLK1_I = ~CLK1_I;

   // model: edges since reset decide the phase; bus rules applied per state
   int         n;
   bit         m_se, m_ack, m_wr;
   logic       m_sync, m_oe, m_irv, m_rdv, m_inta;
   logic [2:0] m_s;
   logic [7:0] m_d, m_ir, m_rd;
   always @(posedge CLK1_I) begin
      if (!nRST_I) begin
         n = 0; m_se = 0; m_ack = 0; m_sync = 0; m_s = 0; m_d = 0; m_oe = 0;
         m_ir = 0; m_rd = 0; m_irv = 0; m_rdv = 0; m_inta = 0;
      end else begin
         n++;
         m_se = (n % 2 == 0);
         m_sync = (n % 2 == 1);
         m_s = (CYCLE_I == CI) ? 3'b000 : STATE_I;
         m_irv = 0; m_rdv = 0; m_inta = 0;
         m_wr = (CTYPE_I == PCW) && (STATE_I == T3 || STATE_I == WT);
         if (m_se) begin
            if (CYCLE_I == CI) begin
               m_oe = 0; m_ack = 0;
            end else if (STATE_I == T1 || STATE_I == T1I) begin
               m_d = ADDR_I[7:0]; m_oe = 1;
               if (STATE_I == T1I) m_ack = 1;
            end else if (STATE_I == T2) begin
               m_d = {CTYPE_I, ADDR_I[13:8]}; m_oe = 1;
            end else if (m_wr) begin
               m_d = WDATA_I; m_oe = 1;
            end else begin
               m_oe = 0;
               if (STATE_I == T3 && CYCLE_I == C1) begin
                  m_ir = D_I; m_irv = 1; m_inta = m_ack; m_ack = 0;
               end else if (STATE_I == T3) begin
                  m_rd = D_I; m_rdv = 1;
               end
            end
         end
      end
   end

   task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // every cycle, all outputs against the model
   always @(negedge CLK1_I) if (armed) begin
      cmp("sync", SYNC_O, m_sync);
      cmp("s_pins", S_O, m_s);
      cmp("d_out", D_O, m_d);
      cmp("d_oe", D_OE_O, m_oe);
      cmp("ir", IR_O, m_ir);
      cmp("ir_vld", IR_VLD_O, m_irv);
      cmp("rdata", RDATA_O, m_rd);
      cmp("rdata_vld", RDATA_VLD_O, m_rdv);
      cmp("inta", INTA_O, m_inta);
      cmp("pc_hold", PC_HOLD_O, m_ack);
   end

   // apply sequencer inputs and advance past the next state edge
   task automatic step(input logic [2:0] st, input logic [1:0] cy, input logic [1:0] ct,
                       input logic [13:0] a, input logic [7:0] w, input logic [7:0] d);
      STATE_I = st; CYCLE_I = cy; CTYPE_I = ct; ADDR_I = a; WDATA_I = w; D_I = d;
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK1_I); #1;
         if (m_se) return;
      end
      checks++; errors++;
      $display("FAIL state_edge: no state edge within 3 clocks at %0t", $time);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      nRST_I = 0; STATE_I = STP; CYCLE_I = C1; CTYPE_I = PCI; ADDR_I = 0; WDATA_I = 0; D_I = 0;
      repeat (2) @(posedge CLK1_I);
      #1 armed = 1;
      cmp("rst_sync", SYNC_O, 8'd0);
      cmp("rst_oe", D_OE_O, 8'd0);
      nRST_I = 1;
      for (int i = 1; i < 6; i++) begin
         @(posedge CLK1_I); #1;
         cmp("sync_seq", SYNC_O, 8'(i % 2));
         cmp("idle_oe", D_OE_O, 8'd0);
         cmp("idle_pulses", {IR_VLD_O, RDATA_VLD_O, INTA_O}, 8'd0);
      end
      // C1 opcode fetch
      step(T1, C1, PCI, 14'h2A5C, 8'h00, 8'h00);
      cmp("c1_t1_d", D_O, 8'h5C); cmp("c1_t1_oe", D_OE_O, 8'd1);
      step(T2, C1, PCI, 14'h2A5C, 8'h00, 8'h00);
      cmp("c1_t2_d", D_O, 8'h2A);
      step(T3, C1, PCI, 14'h2A5C, 8'h00, 8'h44);
      cmp("c1_ir", IR_O, 8'h44); cmp("c1_irv", IR_VLD_O, 8'd1); cmp("c1_oe", D_OE_O, 8'd0);
      @(posedge CLK1_I); #1;
      cmp("c1_irv_off", IR_VLD_O, 8'd0);
      step(T4, C1, PCI, 14'h2A5C, 8'h00, 8'h00);
      step(T5, C1, PCI, 14'h2A5C, 8'h00, 8'h00);
      // C3 write
      step(T1, C3, PCW, 14'h1234, 8'hC3, 8'h00);
      cmp("pcw_t1_d", D_O, 8'h34);
      step(T2, C3, PCW, 14'h1234, 8'hC3, 8'h00);
      cmp("pcw_t2_d", D_O, 8'hD2);
      step(T3, C3, PCW, 14'h1234, 8'hC3, 8'hFF);
      cmp("pcw_t3_d", D_O, 8'hC3); cmp("pcw_t3_oe", D_OE_O, 8'd1); cmp("pcw_rdv", RDATA_VLD_O, 8'd0);
      step(T4, C3, PCW, 14'h1234, 8'hC3, 8'hFF);
      cmp("pcw_t4_oe", D_OE_O, 8'd0); cmp("pcw_t4_d", D_O, 8'hC3);
      // C2 read with three wait states
      step(T1, C2, PCR, 14'h0F81, 8'h00, 8'h00);
      step(T2, C2, PCR, 14'h0F81, 8'h00, 8'h00);
      cmp("pcr_t2_d", D_O, 8'h8F);
      for (int i = 0; i < 3; i++) begin
         step(WT, C2, PCR, 14'h0F81, 8'h00, 8'h11);
         cmp("pcr_wait_oe", D_OE_O, 8'd0); cmp("pcr_wait_rdv", RDATA_VLD_O, 8'd0);
      end
      step(T3, C2, PCR, 14'h0F81, 8'h00, 8'h7E);
      cmp("pcr_rdata", RDATA_O, 8'h7E); cmp("pcr_rdv", RDATA_VLD_O, 8'd1);
      step(T4, C2, PCR, 14'h0F81, 8'h00, 8'h00);
      // interrupt acknowledge fetch, with a repeated T1I
      step(STP, C1, PCI, 14'h0100, 8'h00, 8'h00);
      step(T1I, C1, PCI, 14'h0100, 8'h00, 8'h00);
      cmp("ack_hold", PC_HOLD_O, 8'd1); cmp("ack_t1i_d", D_O, 8'h00);
      step(T1I, C1, PCI, 14'h0100, 8'h00, 8'h00);
      cmp("ack_hold2", PC_HOLD_O, 8'd1);
      step(T2, C1, PCI, 14'h0100, 8'h00, 8'h00);
      step(T3, C1, PCI, 14'h0100, 8'h00, 8'h05);
      cmp("ack_ir", IR_O, 8'h05); cmp("ack_irv", IR_VLD_O, 8'd1);
      cmp("ack_inta", INTA_O, 8'd1); cmp("ack_hold_clr", PC_HOLD_O, 8'd0);
      step(T4, C1, PCI, 14'h0100, 8'h00, 8'h00);
      // INIT cancels a pending acknowledge
      step(T1I, C1, PCI, 14'h0200, 8'h00, 8'h00);
      step(STP, CI, PCI, 14'h0200, 8'h00, 8'h00);
      cmp("init_hold", PC_HOLD_O, 8'd0); cmp("init_oe", D_OE_O, 8'd0); cmp("init_s", S_O, 8'd0);
      // reset during a read T3
      step(T1, C2, PCR, 14'h0033, 8'h00, 8'h00);
      step(T2, C2, PCR, 14'h0033, 8'h00, 8'h00);
      STATE_I = T3; D_I = 8'h99; nRST_I = 0;
      repeat (2) begin
         @(posedge CLK1_I); #1;
         cmp("rst_rdv", RDATA_VLD_O, 8'd0);
      end
      cmp("rst_rdata", RDATA_O, 8'h00); cmp("rst_ir", IR_O, 8'h00);
      cmp("rst_d", D_O, 8'h00); cmp("rst_sync2", SYNC_O, 8'd0);
      nRST_I = 1;
      repeat (6) @(posedge CLK1_I);
      #1 armed = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
